// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write, issue and scoreboard signals of the multi-port register file
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic [NUM_WR-1:0]        wr_en_i;
  logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic                     iss_en_i;
  logic [ADDR_W-1:0]        iss_addr_i;
  logic                     flush_i;
  logic [ADDR_W:0]          busy_cnt_o;

  // pipeline side: decode/issue and writeback stages
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  // register file side
  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write bypass and busy-bit scoreboard
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int SP_IDX   = 2,
  parameter int SP_INIT  = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;

  // Register 0 is a constant zero: never written, never busy, never bypassed.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Storage update; ports are applied in ascending order so the highest index wins a conflict.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en_i[k] && !is_zero(bus.wr_addr_i[k*ADDR_W +: ADDR_W])) begin
          regs[bus.wr_addr_i[k*ADDR_W +: ADDR_W]] <= bus.wr_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next busy vector: flush beats everything, then writes clear, then an issue sets (new producer).
  always_comb begin
    busy_d = busy_q;
    if (bus.flush_i) begin
      busy_d = '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en_i[k]) begin
          busy_d[bus.wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
      if (bus.iss_en_i && !is_zero(bus.iss_addr_i)) begin
        busy_d[bus.iss_addr_i] = 1'b1;
      end
    end
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Scoreboard state and its population count, both reflecting the post-update vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Combinational read ports; a same-cycle write is forwarded and masks the busy bit it resolves.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              bsy;
    ra   = '0;
    data = '0;
    bsy  = 1'b0;
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra   = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
      data = regs[ra];
      bsy  = busy_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en_i[k] && (bus.wr_addr_i[k*ADDR_W +: ADDR_W] == ra)) begin
            data = bus.wr_data_i[k*DATA_W +: DATA_W];
            bsy  = 1'b0;
          end
        end
      end
      if (is_zero(ra)) begin
        data = '0;
        bsy  = 1'b0;
      end
      bus.rd_data_o[p*DATA_W +: DATA_W] = data;
      bus.rd_busy_o[p] = bsy;
    end
  end

  assign bus.busy_cnt_o = busy_cnt_q;

endmodule
